// File: rtl/atm_bank_pkg.sv
// Op codes, status codes, FSM states and default sizing shared by the ATM controller and the bank server.
// No logic here; the PIN lockout option (BANK_PIN_LOCKOUT_EN) is selected in the bank RTL.
package atm_bank_pkg;

    localparam int DEF_NUM_ACCTS = 4;
    localparam int DEF_CARD_W    = 8;
    localparam int DEF_PIN_W     = 4;
    localparam int DEF_AMT_W     = 5;
    localparam int DEF_BAL_W     = 5;
    localparam int DEF_INIT_BAL  = 10;
    localparam int DEF_PIN_BASE  = 4;
    localparam int MAX_PIN_TRIES = 3;
    localparam int FAIL_CNT_W    = $clog2(MAX_PIN_TRIES + 1);

    typedef enum logic [2:0] {
        OP_LOGOUT     = 3'd0,
        OP_DEPOSIT    = 3'd1,
        OP_WITHDRAW   = 3'd2,
        OP_BALANCE    = 3'd3,
        OP_VERIFY_PIN = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_OK          = 3'd0,
        ST_BAD_CARD    = 3'd1,
        ST_BAD_PIN     = 3'd2,
        ST_NO_AUTH     = 3'd3,
        ST_INSUF_FUNDS = 3'd4,
        ST_OVERFLOW    = 3'd5,
        ST_LOCKED      = 3'd6,
        ST_BAD_OP      = 3'd7
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_VERIFY_PIN;
    endfunction

endpackage

// File: rtl/account_ledger.sv
// Per-account balance / PIN / fail-counter registers with one comb read port and one write port.
// Read is zero latency; write lands on the clock edge. Fail counters exist only with BANK_PIN_LOCKOUT_EN.
// No backpressure: the caller owns sequencing and issues at most one write per transaction.
module account_ledger
    import atm_bank_pkg::*;
#(
    parameter int NUM_ACCTS = DEF_NUM_ACCTS,
    parameter int PIN_W     = DEF_PIN_W,
    parameter int BAL_W     = DEF_BAL_W,
    parameter int INIT_BAL  = DEF_INIT_BAL,
    parameter int PIN_BASE  = DEF_PIN_BASE,
    parameter int IDX_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [BAL_W-1:0]      rd_bal_o,
    output logic [PIN_W-1:0]      rd_pin_o,
`ifdef BANK_PIN_LOCKOUT_EN
    output logic [FAIL_CNT_W-1:0] rd_fail_o,
    input  logic [FAIL_CNT_W-1:0] wr_fail_i,
`endif
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [BAL_W-1:0]      wr_bal_i
);

    logic [BAL_W-1:0] bal_q [NUM_ACCTS];
    logic [PIN_W-1:0] pin_q [NUM_ACCTS];

    // PINs are only ever (re)loaded by reset; there is no PIN-change operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                bal_q[i] <= BAL_W'(INIT_BAL);
                pin_q[i] <= PIN_W'(PIN_BASE + i + 1);
            end
        end else if (wr_en_i) begin
            bal_q[wr_idx_i] <= wr_bal_i;
        end
    end

    assign rd_bal_o = bal_q[rd_idx_i];
    assign rd_pin_o = pin_q[rd_idx_i];

`ifdef BANK_PIN_LOCKOUT_EN
    logic [FAIL_CNT_W-1:0] fail_q [NUM_ACCTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                fail_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            fail_q[wr_idx_i] <= wr_fail_i;
        end
    end

    assign rd_fail_o = fail_q[rd_idx_i];
`endif

endmodule

// File: rtl/bank_account_server.sv
// Bank responder: one request at a time through IDLE -> EXEC -> RESP; BANK_PIN_LOCKOUT_EN enables PIN lockout.
// Latency: request accepted on edge T, ledger written and response registered on edge T+1, consumed at T+2 or later.
// Backpressure: req_ready only in IDLE; response fields held stable until rsp_ready.
module bank_account_server
    import atm_bank_pkg::*;
#(
    parameter int NUM_ACCTS = DEF_NUM_ACCTS,
    parameter int CARD_W    = DEF_CARD_W,
    parameter int PIN_W     = DEF_PIN_W,
    parameter int AMT_W     = DEF_AMT_W,
    parameter int BAL_W     = DEF_BAL_W,
    parameter int INIT_BAL  = DEF_INIT_BAL,
    parameter int PIN_BASE  = DEF_PIN_BASE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [CARD_W-1:0] req_card,
    input  logic [PIN_W-1:0]  req_pin,
    input  logic [AMT_W-1:0]  req_amount,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_status,
    output logic [BAL_W-1:0]  rsp_balance,
    output logic [CARD_W-1:0] rsp_card
);

    localparam int IDX_W = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1;

    state_e            state_q, state_d;
    logic [2:0]        op_q;
    logic [CARD_W-1:0] card_q;
    logic [PIN_W-1:0]  pin_q;
    logic [AMT_W-1:0]  amt_q;
    logic [IDX_W-1:0]  sess_idx_q, sess_idx_d;
    logic              sess_auth_q, sess_auth_d;
    logic [2:0]        status_q, status_d;
    logic [BAL_W-1:0]  bal_q, bal_d;

    logic [IDX_W-1:0]  idx;
    logic [BAL_W-1:0]  rd_bal, wr_bal;
    logic [PIN_W-1:0]  rd_pin;
    logic              wr_en, card_ok;
    logic [BAL_W:0]    amt_ext, sum;

    assign idx     = IDX_W'(card_q - CARD_W'(1));
    assign card_ok = (card_q != '0) && (card_q <= CARD_W'(NUM_ACCTS));
    assign amt_ext = (BAL_W+1)'(amt_q);
    assign sum     = {1'b0, rd_bal} + amt_ext;

`ifdef BANK_PIN_LOCKOUT_EN
    logic [FAIL_CNT_W-1:0] rd_fail, wr_fail, fail_inc;
    logic                  locked;
    assign fail_inc = rd_fail + FAIL_CNT_W'(1);
    assign locked   = rd_fail >= FAIL_CNT_W'(MAX_PIN_TRIES);
`endif

    account_ledger #(
        .NUM_ACCTS (NUM_ACCTS),
        .PIN_W     (PIN_W),
        .BAL_W     (BAL_W),
        .INIT_BAL  (INIT_BAL),
        .PIN_BASE  (PIN_BASE),
        .IDX_W     (IDX_W)
    ) u_ledger (
        .clk       (clk),
        .rst       (rst),
        .rd_idx_i  (idx),
        .rd_bal_o  (rd_bal),
        .rd_pin_o  (rd_pin),
`ifdef BANK_PIN_LOCKOUT_EN
        .rd_fail_o (rd_fail),
        .wr_fail_i (wr_fail),
`endif
        .wr_en_i   (wr_en),
        .wr_idx_i  (idx),
        .wr_bal_i  (wr_bal)
    );

    always_comb begin
        state_d     = state_q;
        sess_idx_d  = sess_idx_q;
        sess_auth_d = sess_auth_q;
        status_d    = status_q;
        bal_d       = bal_q;
        wr_en       = 1'b0;
        wr_bal      = rd_bal;
`ifdef BANK_PIN_LOCKOUT_EN
        wr_fail     = rd_fail;
`endif
        case (state_q)
            S_IDLE: if (req_valid) state_d = S_EXEC;
            S_EXEC: begin
                state_d  = S_RESP;
                status_d = ST_OK;
                bal_d    = '0;
                if (!is_legal_op(op_q)) begin
                    status_d = ST_BAD_OP;
                end else if (op_q == OP_LOGOUT) begin
                    sess_idx_d  = '0;
                    sess_auth_d = 1'b0;
                end else if (!card_ok) begin
                    status_d = ST_BAD_CARD;
                    if (op_q == OP_VERIFY_PIN) sess_auth_d = 1'b0;
`ifdef BANK_PIN_LOCKOUT_EN
                end else if (locked) begin
                    status_d = ST_LOCKED;
                    if (op_q == OP_VERIFY_PIN) begin
                        sess_idx_d  = idx;
                        sess_auth_d = 1'b0;
                    end
`endif
                end else if (op_q == OP_VERIFY_PIN) begin
                    sess_idx_d  = idx;
                    sess_auth_d = (pin_q == rd_pin);
                    if (pin_q == rd_pin) begin
                        bal_d = rd_bal;
`ifdef BANK_PIN_LOCKOUT_EN
                        wr_en   = 1'b1;
                        wr_fail = '0;
`endif
                    end else begin
                        status_d = ST_BAD_PIN;
`ifdef BANK_PIN_LOCKOUT_EN
                        wr_en   = 1'b1;
                        wr_fail = fail_inc;
                        if (fail_inc >= FAIL_CNT_W'(MAX_PIN_TRIES)) status_d = ST_LOCKED;
`endif
                    end
                end else if (!(sess_auth_q && sess_idx_q == idx)) begin
                    status_d = ST_NO_AUTH;
                end else if (op_q != OP_BALANCE && amt_q == '0) begin
                    status_d = ST_BAD_OP;
                end else if (op_q == OP_DEPOSIT) begin
                    bal_d = rd_bal;
                    if (sum[BAL_W]) begin
                        status_d = ST_OVERFLOW;
                    end else begin
                        bal_d  = sum[BAL_W-1:0];
                        wr_en  = 1'b1;
                        wr_bal = sum[BAL_W-1:0];
                    end
                end else if (op_q == OP_WITHDRAW) begin
                    bal_d = rd_bal;
                    if (amt_ext <= {1'b0, rd_bal}) begin
                        bal_d  = rd_bal - BAL_W'(amt_q);
                        wr_en  = 1'b1;
                        wr_bal = rd_bal - BAL_W'(amt_q);
                    end else begin
                        status_d = ST_INSUF_FUNDS;
                    end
                end else begin
                    bal_d = rd_bal;
                end
            end
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            card_q      <= '0;
            pin_q       <= '0;
            amt_q       <= '0;
            sess_idx_q  <= '0;
            sess_auth_q <= 1'b0;
            status_q    <= '0;
            bal_q       <= '0;
        end else begin
            state_q     <= state_d;
            sess_idx_q  <= sess_idx_d;
            sess_auth_q <= sess_auth_d;
            status_q    <= status_d;
            bal_q       <= bal_d;
            if (state_q == S_IDLE && req_valid) begin
                op_q   <= req_op;
                card_q <= req_card;
                pin_q  <= req_pin;
                amt_q  <= req_amount;
            end
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_status  = status_q;
    assign rsp_balance = bal_q;
    assign rsp_card    = card_q;

endmodule

// File: tb/tb_bank_account_server.sv
// Directed self-checking bench for bank_account_server (default build, lockout expectations under BANK_PIN_LOCKOUT_EN).
module tb_bank_account_server;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_op = '0;
    logic [7:0] req_card = '0;
    logic [3:0] req_pin = '0;
    logic [4:0] req_amount = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [2:0] rsp_status;
    logic [4:0] rsp_balance;
    logic [7:0] rsp_card;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    bank_account_server dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_card    (req_card),
        .req_pin     (req_pin),
        .req_amount  (req_amount),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_status  (rsp_status),
        .rsp_balance (rsp_balance),
        .rsp_card    (rsp_card)
    );

    // Issues one request with rsp_ready high and returns the sampled response.
    task automatic do_req(input logic [2:0] op, input logic [7:0] card, input logic [3:0] pin,
                          input logic [4:0] amt, output logic [2:0] st, output logic [4:0] bal);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_card = card; req_pin = pin; req_amount = amt; rsp_ready = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            ncmp++; nfail++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
        end
        st  = rsp_status;
        bal = rsp_balance;
        @(posedge clk);
    endtask

    task automatic test_reset;
        logic [2:0] st; logic [4:0] bal;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ncmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            nfail++; $display("FAIL reset_hs: rdy=%b vld=%b, required 1/0", req_ready, rsp_valid);
        end
        ncmp++;
        if (rsp_status !== 3'd0 || rsp_balance !== 5'd0 || rsp_card !== 8'd0) begin
            nfail++; $display("FAIL reset_rsp: st=%0d bal=%0d card=%0d, required 0/0/0", rsp_status, rsp_balance, rsp_card);
        end
        rst = 1'b0;
        do_req(3'd3, 8'd1, 4'd0, 5'd0, st, bal);
        ncmp++;
        if (st !== 3'd3 || bal !== 5'd0) begin
            nfail++; $display("FAIL balance_noauth: got %0d/%0d, required 3/0", st, bal);
        end
    endtask

    task automatic test_deposit_withdraw;
        logic [2:0] st; logic [4:0] bal;
        do_req(3'd4, 8'd1, 4'd5, 5'd0, st, bal);
        ncmp++;
        if (st !== 3'd0 || bal !== 5'd10 || rsp_card !== 8'd1) begin
            nfail++; $display("FAIL verify_c1: got %0d/%0d card %0d, required 0/10 card 1", st, bal, rsp_card);
        end
        do_req(3'd1, 8'd1, 4'd0, 5'd7, st, bal);
        ncmp++;
        if (st !== 3'd0 || bal !== 5'd17) begin
            nfail++; $display("FAIL deposit7: got %0d/%0d, required 0/17", st, bal);
        end
        do_req(3'd2, 8'd1, 4'd0, 5'd17, st, bal);
        ncmp++;
        if (st !== 3'd0 || bal !== 5'd0) begin
            nfail++; $display("FAIL withdraw_all: got %0d/%0d, required 0/0", st, bal);
        end
        do_req(3'd2, 8'd1, 4'd0, 5'd1, st, bal);
        ncmp++;
        if (st !== 3'd4 || bal !== 5'd0) begin
            nfail++; $display("FAIL withdraw_insuf: got %0d/%0d, required 4/0", st, bal);
        end
    endtask

    task automatic test_errors;
        logic [2:0] st; logic [4:0] bal;
        do_req(3'd4, 8'd2, 4'd6, 5'd0, st, bal);
        ncmp++;
        if (st !== 3'd0 || bal !== 5'd10) begin
            nfail++; $display("FAIL verify_c2: got %0d/%0d, required 0/10", st, bal);
        end
        do_req(3'd1, 8'd2, 4'd0, 5'd31, st, bal);
        ncmp++;
        if (st !== 3'd5 || bal !== 5'd10) begin
            nfail++; $display("FAIL deposit_ovf: got %0d/%0d, required 5/10", st, bal);
        end
        do_req(3'd1, 8'd2, 4'd0, 5'd21, st, bal);
        ncmp++;
        if (st !== 3'd0 || bal !== 5'd31) begin
            nfail++; $display("FAIL deposit_max: got %0d/%0d, required 0/31", st, bal);
        end
        do_req(3'd1, 8'd2, 4'd0, 5'd0, st, bal);
        ncmp++;
        if (st !== 3'd7 || bal !== 5'd0) begin
            nfail++; $display("FAIL deposit_zero: got %0d/%0d, required 7/0", st, bal);
        end
        do_req(3'd3, 8'd1, 4'd0, 5'd0, st, bal);
        ncmp++;
        if (st !== 3'd3 || bal !== 5'd0) begin
            nfail++; $display("FAIL other_card_noauth: got %0d/%0d, required 3/0", st, bal);
        end
        do_req(3'd4, 8'd0, 4'd4, 5'd0, st, bal);
        ncmp++;
        if (st !== 3'd1 || bal !== 5'd0) begin
            nfail++; $display("FAIL card0: got %0d/%0d, required 1/0", st, bal);
        end
        do_req(3'd4, 8'd5, 4'd9, 5'd0, st, bal);
        ncmp++;
        if (st !== 3'd1 || bal !== 5'd0) begin
            nfail++; $display("FAIL card5: got %0d/%0d, required 1/0", st, bal);
        end
        do_req(3'd6, 8'd1, 4'd5, 5'd3, st, bal);
        ncmp++;
        if (st !== 3'd7 || bal !== 5'd0) begin
            nfail++; $display("FAIL illegal_op: got %0d/%0d, required 7/0", st, bal);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] st; logic [4:0] bal;
        do_req(3'd4, 8'd1, 4'd5, 5'd0, st, bal);
        ncmp++;
        if (st !== 3'd0 || bal !== 5'd0) begin
            nfail++; $display("FAIL reverify_c1: got %0d/%0d, required 0/0", st, bal);
        end
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1; req_card = 8'd1; req_amount = 5'd3; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_op = 3'd3; req_amount = 5'd9;
        @(negedge clk);
        ncmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            nfail++; $display("FAIL exec_phase: vld=%b rdy=%b, required 0/0", rsp_valid, req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ncmp++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_status !== 3'd0 ||
                rsp_balance !== 5'd3 || rsp_card !== 8'd1) begin
                nfail++;
                $display("FAIL hold_stable[%0d]: vld=%b rdy=%b st=%0d bal=%0d card=%0d, required 1/0/0/3/1",
                         i, rsp_valid, req_ready, rsp_status, rsp_balance, rsp_card);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        ncmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            nfail++; $display("FAIL release_idle: rdy=%b vld=%b, required 1/0", req_ready, rsp_valid);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        ncmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            nfail++; $display("FAIL next_exec: vld=%b rdy=%b, required 0/0", rsp_valid, req_ready);
        end
        @(negedge clk);
        ncmp++;
        if (rsp_valid !== 1'b1 || rsp_status !== 3'd0 || rsp_balance !== 5'd3) begin
            nfail++; $display("FAIL next_rsp: vld=%b st=%0d bal=%0d, required 1/0/3", rsp_valid, rsp_status, rsp_balance);
        end
        @(posedge clk);
    endtask

    task automatic test_pin_lockout;
        logic [2:0] st; logic [4:0] bal;
        logic [2:0] exp_st [4];
`ifdef BANK_PIN_LOCKOUT_EN
        exp_st[0] = 3'd2; exp_st[1] = 3'd2; exp_st[2] = 3'd6; exp_st[3] = 3'd6;
`else
        exp_st[0] = 3'd2; exp_st[1] = 3'd2; exp_st[2] = 3'd2; exp_st[3] = 3'd0;
`endif
        for (int i = 0; i < 3; i++) begin
            do_req(3'd4, 8'd3, 4'd0, 5'd0, st, bal);
            ncmp++;
            if (st !== exp_st[i] || bal !== 5'd0) begin
                nfail++; $display("FAIL badpin[%0d]: got %0d/%0d, required %0d/0", i, st, bal, exp_st[i]);
            end
        end
        do_req(3'd4, 8'd3, 4'd7, 5'd0, st, bal);
        ncmp++;
        if (st !== exp_st[3] || bal !== ((exp_st[3] == 3'd0) ? 5'd10 : 5'd0)) begin
            nfail++; $display("FAIL goodpin_after: got %0d/%0d, required %0d", st, bal, exp_st[3]);
        end
    endtask

    task automatic test_reset_in_resp;
        logic [2:0] st; logic [4:0] bal;
        int n;
        do_req(3'd4, 8'd1, 4'd5, 5'd0, st, bal);
        ncmp++;
        if (st !== 3'd0 || bal !== 5'd3) begin
            nfail++; $display("FAIL verify_c1_b: got %0d/%0d, required 0/3", st, bal);
        end
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1; req_card = 8'd1; req_amount = 5'd5; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        ncmp++;
        if (rsp_valid !== 1'b1 || rsp_balance !== 5'd8) begin
            nfail++; $display("FAIL deposit5_rsp: vld=%b bal=%0d, required 1/8", rsp_valid, rsp_balance);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rsp_ready = 1'b1;
        ncmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            nfail++; $display("FAIL rst_in_resp: vld=%b rdy=%b, required 0/1", rsp_valid, req_ready);
        end
        do_req(3'd3, 8'd3, 4'd0, 5'd0, st, bal);
        ncmp++;
        if (st !== 3'd3 || bal !== 5'd0) begin
            nfail++; $display("FAIL session_cleared: got %0d/%0d, required 3/0", st, bal);
        end
        do_req(3'd4, 8'd1, 4'd5, 5'd0, st, bal);
        ncmp++;
        if (st !== 3'd0 || bal !== 5'd10) begin
            nfail++; $display("FAIL verify_after_rst: got %0d/%0d, required 0/10", st, bal);
        end
        do_req(3'd0, 8'd9, 4'd0, 5'd0, st, bal);
        do_req(3'd3, 8'd1, 4'd0, 5'd0, st, bal);
        ncmp++;
        if (st !== 3'd3 || bal !== 5'd0) begin
            nfail++; $display("FAIL after_logout: got %0d/%0d, required 3/0", st, bal);
        end
    endtask

    initial begin
        test_reset;
        test_deposit_withdraw;
        test_errors;
        test_back_to_back;
        test_pin_lockout;
        test_reset_in_resp;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule
